// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: classifies each instruction, extends its immediate to XLEN,
// precomputes PC-relative targets, and buffers results in a two-entry valid/ready skid buffer.
module imm_decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter bit          F_EXT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  localparam int unsigned ILEN = 32;
  localparam int unsigned FW   = 3;

  localparam logic [FW-1:0] FMT_NONE  = 3'd0;
  localparam logic [FW-1:0] FMT_I     = 3'd1;
  localparam logic [FW-1:0] FMT_S     = 3'd2;
  localparam logic [FW-1:0] FMT_B     = 3'd3;
  localparam logic [FW-1:0] FMT_U     = 3'd4;
  localparam logic [FW-1:0] FMT_J     = 3'd5;
  localparam logic [FW-1:0] FMT_SHAMT = 3'd6;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FLOAD  = 7'b0000111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_FSTORE = 7'b0100111;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPFP   = 7'b1010011;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [FW-1:0]   fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  logic [ILEN-1:0] imm32;
  logic [5:0]      shamt;
  logic            pc_rel;
  entry_t          dec;

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid, main_valid_d, skid_valid, skid_valid_d;
  logic   in_ready_q, in_ready_d;
  logic   accept;

  // SHAMT width follows XLEN: 5 bits on RV32, 6 bits on RV64
  assign shamt = (XLEN == 64) ? in_instr[25:20] : {1'b0, in_instr[24:20]};

  // Opcode classification, immediate extraction and target precompute
  always_comb begin
    imm32       = '0;
    pc_rel      = 1'b0;
    dec.instr   = in_instr;
    dec.pc      = in_pc;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    case (in_instr[6:0])
      OP_LUI: begin
        imm32   = {in_instr[31:12], 12'b0};
        dec.fmt = FMT_U;
      end
      OP_AUIPC: begin
        imm32   = {in_instr[31:12], 12'b0};
        dec.fmt = FMT_U;
        pc_rel  = 1'b1;
      end
      OP_JAL: begin
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
        dec.fmt = FMT_J;
        pc_rel  = 1'b1;
      end
      OP_JALR, OP_LOAD: begin
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.fmt = FMT_I;
      end
      OP_FLOAD: begin
        if (F_EXT) begin
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
          dec.fmt = FMT_I;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_BRANCH: begin
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
        dec.fmt = FMT_B;
        pc_rel  = 1'b1;
      end
      OP_STORE: begin
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        dec.fmt = FMT_S;
      end
      OP_FSTORE: begin
        if (F_EXT) begin
          imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
          dec.fmt = FMT_S;
        end else begin
          dec.illegal = 1'b1;
        end
      end
      OP_OPIMM: begin
        if (in_instr[14:12] == 3'b001 || in_instr[14:12] == 3'b101) begin
          dec.fmt = FMT_SHAMT;
        end else begin
          imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
          dec.fmt = FMT_I;
        end
      end
      OP_OP: begin
        dec.fmt = FMT_NONE;
      end
      OP_OPFP: begin
        dec.illegal = !F_EXT;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase

    if (dec.fmt == FMT_SHAMT) begin
      dec.imm = XLEN'(shamt);
    end else begin
      dec.imm = XLEN'($signed(imm32));
    end
    dec.target = pc_rel ? (in_pc + dec.imm) : '0;
  end

  assign accept = in_valid && in_ready_q;

  // Skid-buffer next state; flush wins over every other update
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid;
    skid_valid_d = skid_valid;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid || out_ready) begin
      if (skid_valid) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid;
  assign out_instr   = main_q.instr;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_target  = main_q.target;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: three configurations (RV32+F, RV64+F, RV32 without F) driven in
// lockstep and checked against an arithmetic reference decoder and an occupancy/ordering model.
module tb_imm_decode_stage;

  localparam int unsigned PW = 228;
  typedef logic [PW-1:0] pack_t;
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic        a_ready, a_valid, a_ill;
  logic [31:0] a_instr, a_pc, a_imm, a_tgt;
  logic [2:0]  a_fmt;
  logic        b_ready, b_valid, b_ill;
  logic [31:0] b_instr;
  logic [63:0] b_pc, b_imm, b_tgt;
  logic [2:0]  b_fmt;
  logic        c_ready, c_valid, c_ill;
  logic [31:0] c_instr, c_pc, c_imm, c_tgt;
  logic [2:0]  c_fmt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .F_EXT(1'b1)) u32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_valid), .out_ready(out_ready),
    .out_instr(a_instr), .out_pc(a_pc), .out_imm(a_imm), .out_fmt(a_fmt),
    .out_target(a_tgt), .out_illegal(a_ill));

  imm_decode_stage #(.XLEN(64), .F_EXT(1'b1)) u64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_valid), .out_ready(out_ready),
    .out_instr(b_instr), .out_pc(b_pc), .out_imm(b_imm), .out_fmt(b_fmt),
    .out_target(b_tgt), .out_illegal(b_ill));

  imm_decode_stage #(.XLEN(32), .F_EXT(1'b0)) unf (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(c_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(c_valid), .out_ready(out_ready),
    .out_instr(c_instr), .out_pc(c_pc), .out_imm(c_imm), .out_fmt(c_fmt),
    .out_target(c_tgt), .out_illegal(c_ill));

  pack_t obs_a, obs_b, obs_c;
  assign obs_a = {a_instr, 32'h0, a_pc, 32'h0, a_imm, a_fmt, 32'h0, a_tgt, a_ill};
  assign obs_b = {b_instr, b_pc, b_imm, b_fmt, b_tgt, b_ill};
  assign obs_c = {c_instr, 32'h0, c_pc, 32'h0, c_imm, c_fmt, 32'h0, c_tgt, c_ill};

  // Reference decoder: immediates assembled by signed arithmetic on the instruction word
  function automatic pack_t exp_pack(input logic [31:0] instr, input logic [63:0] pc,
                                     input bit x64, input bit fext);
    longint      si, hi, v;
    logic [63:0] imm, tgt, mask;
    logic [2:0]  fmt;
    logic        ill;
    bit          pcrel;
    logic [6:0]  op;
    logic [2:0]  f3;
    si = longint'($signed(instr));
    hi = si >>> 31;
    v = 0; fmt = 3'd0; ill = 1'b0; pcrel = 1'b0;
    op = instr[6:0];
    f3 = instr[14:12];
    case (op)
      7'b0110111: begin v = si >>> 12; v = v * 4096; fmt = 3'd4; end
      7'b0010111: begin v = si >>> 12; v = v * 4096; fmt = 3'd4; pcrel = 1'b1; end
      7'b1101111: begin
        v = hi * 1048576 + longint'(((instr >> 12) & 255) << 12)
          + longint'(((instr >> 20) & 1) << 11) + longint'(((instr >> 21) & 1023) << 1);
        fmt = 3'd5; pcrel = 1'b1;
      end
      7'b1100111, 7'b0000011: begin v = si >>> 20; fmt = 3'd1; end
      7'b0000111: if (fext) begin v = si >>> 20; fmt = 3'd1; end else ill = 1'b1;
      7'b1100011: begin
        v = hi * 4096 + longint'(((instr >> 7) & 1) << 11)
          + longint'(((instr >> 25) & 63) << 5) + longint'(((instr >> 8) & 15) << 1);
        fmt = 3'd3; pcrel = 1'b1;
      end
      7'b0100011: begin v = si >>> 25; v = v * 32 + longint'((instr >> 7) & 31); fmt = 3'd2; end
      7'b0100111: if (fext) begin
        v = si >>> 25; v = v * 32 + longint'((instr >> 7) & 31); fmt = 3'd2;
      end else ill = 1'b1;
      7'b0010011: begin
        if (f3 == 3'd1 || f3 == 3'd5) begin
          v = x64 ? longint'((instr >> 20) & 63) : longint'((instr >> 20) & 31);
          fmt = 3'd6;
        end else begin
          v = si >>> 20; fmt = 3'd1;
        end
      end
      7'b0110011: fmt = 3'd0;
      7'b1010011: ill = !fext;
      default: ill = 1'b1;
    endcase
    mask = x64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    imm = 64'(v) & mask;
    tgt = pcrel ? ((pc + imm) & mask) : 64'h0;
    return {instr, pc & mask, imm, fmt, tgt, ill};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [6:0]  ops [16];
    logic [31:0] r;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0000111,
            7'b1100011, 7'b0100011, 7'b0100111, 7'b0010011, 7'b0010011, 7'b0110011,
            7'b1010011, 7'b1111111, 7'b0001011, 7'b0000000};
    r = $urandom;
    return (r & 32'hFFFF_FF80) | 32'(ops[$urandom_range(0, 15)]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    n_tests++;
    if ({a_ready, b_ready, c_ready, a_valid, b_valid, c_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: ready=%b%b%b valid=%b%b%b want all 0",
               a_ready, b_ready, c_ready, a_valid, b_valid, c_valid);
    end
    n_tests++;
    if (obs_a !== '0 || obs_b !== '0 || obs_c !== '0) begin
      n_fail++;
      $display("FAIL reset_data: a=%h b=%h c=%h want 0", obs_a, obs_b, obs_c);
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (a_ready !== 1'b1 || a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", a_ready, a_valid);
    end
  endtask

  task automatic test_decode();
    logic [31:0] ti [17];
    logic [63:0] tp [17];
    ti = '{32'hFFF00093, 32'h0080006F, 32'hFE000EE3, 32'hFE000EE3, 32'h800000B7,
           32'h03F01093, 32'h0000A007, 32'h0000007F, 32'hFFFFF517, 32'h00C50567,
           32'hFE112E23, 32'h00B50533, 32'h00107053, 32'h00A12027, 32'h40515513,
           32'h8FF57513, 32'h0200006F};
    tp = '{64'h100, 64'h1000, 64'h0, 64'h2, 64'h0, 64'h0, 64'h40, 64'h0,
           64'h0000_0001_8000_0000, 64'h200, 64'h0, 64'h0, 64'h0, 64'h10, 64'h0, 64'h0,
           64'hFFFF_FFFF_FFFF_FFF0};
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_instr = ti[i]; in_pc = tp[i];
      step();
      in_valid = 1'b0;
      n_tests++;
      if (a_valid !== 1'b1 || obs_a !== exp_pack(ti[i], tp[i], 1'b0, 1'b1)) begin
        n_fail++;
        $display("FAIL decode32[%0d]: valid=%b got %h want %h", i, a_valid, obs_a,
                 exp_pack(ti[i], tp[i], 1'b0, 1'b1));
      end
      n_tests++;
      if (b_valid !== 1'b1 || obs_b !== exp_pack(ti[i], tp[i], 1'b1, 1'b1)) begin
        n_fail++;
        $display("FAIL decode64[%0d]: valid=%b got %h want %h", i, b_valid, obs_b,
                 exp_pack(ti[i], tp[i], 1'b1, 1'b1));
      end
      n_tests++;
      if (c_valid !== 1'b1 || obs_c !== exp_pack(ti[i], tp[i], 1'b0, 1'b0)) begin
        n_fail++;
        $display("FAIL decode_nof[%0d]: valid=%b got %h want %h", i, c_valid, obs_c,
                 exp_pack(ti[i], tp[i], 1'b0, 1'b0));
      end
      case (i)
        0: begin
          n_tests++;
          if ({a_imm, a_fmt, a_tgt, a_ill} !== {32'hFFFF_FFFF, 3'd1, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL addi_m1: imm=%h fmt=%0d tgt=%h ill=%b", a_imm, a_fmt, a_tgt, a_ill);
          end
        end
        1: begin
          n_tests++;
          if ({a_imm, a_fmt, a_tgt} !== {32'h8, 3'd5, 32'h1008}) begin
            n_fail++;
            $display("FAIL jal: imm=%h fmt=%0d tgt=%h want 8/5/1008", a_imm, a_fmt, a_tgt);
          end
        end
        4: begin
          n_tests++;
          if (b_imm !== 64'hFFFF_FFFF_8000_0000 || b_fmt !== 3'd4) begin
            n_fail++;
            $display("FAIL lui64: imm=%h fmt=%0d", b_imm, b_fmt);
          end
        end
        5: begin
          n_tests++;
          if (b_imm !== 64'h3F || b_fmt !== 3'd6 || a_imm !== 32'h1F) begin
            n_fail++;
            $display("FAIL slli63: imm64=%h fmt=%0d imm32=%h want 3f/6/1f", b_imm, b_fmt, a_imm);
          end
        end
        6: begin
          n_tests++;
          if ({c_ill, c_fmt, c_imm} !== {1'b1, 3'd0, 32'h0} || a_ill !== 1'b0) begin
            n_fail++;
            $display("FAIL fload_nof: ill=%b fmt=%0d imm=%h f_ill=%b", c_ill, c_fmt, c_imm, a_ill);
          end
        end
        7: begin
          n_tests++;
          if (a_ill !== 1'b1 || c_ill !== 1'b1 || a_fmt !== 3'd0) begin
            n_fail++;
            $display("FAIL op7f: ill=%b/%b fmt=%0d want 1/1/0", a_ill, c_ill, a_fmt);
          end
        end
        default: ;
      endcase
    end
    step();
  endtask

  // rnd=1: random valid/ready; rnd=0: continuous input with a single out_ready drop
  task automatic test_stream(input int n, input bit rnd);
    item_t q[$];
    item_t it;
    int    sent, rcvd;
    bit    stalled;
    pack_t snap_a, snap_b;
    sent = 0; rcvd = 0; stalled = 1'b0; snap_a = '0; snap_b = '0;
    in_valid = 1'b0; out_ready = 1'b0;
    for (int cyc = 0; cyc < 400 && rcvd < n; cyc++) begin
      step();
      n_tests++;
      if (a_ready !== (q.size() < 2) || a_valid !== (q.size() > 0) ||
          b_ready !== a_ready || c_valid !== a_valid) begin
        n_fail++;
        $display("FAIL stream_flow cyc%0d: in_ready=%b out_valid=%b occupancy=%0d",
                 cyc, a_ready, a_valid, q.size());
      end
      if (stalled) begin
        n_tests++;
        if (obs_a !== snap_a || obs_b !== snap_b) begin
          n_fail++;
          $display("FAIL stall_stable cyc%0d: got %h want %h", cyc, obs_a, snap_a);
        end
      end
      if (sent < n && (!rnd || $urandom_range(0, 4) != 0)) begin
        in_valid = 1'b1;
        in_instr = gen_instr();
        in_pc    = {32'($urandom), 32'($urandom)} & ~64'h3;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc != 2);
      if (a_valid && out_ready) begin
        it = q.pop_front();
        rcvd++;
        n_tests++;
        if (obs_a !== exp_pack(it.instr, it.pc, 1'b0, 1'b1) ||
            obs_b !== exp_pack(it.instr, it.pc, 1'b1, 1'b1) ||
            obs_c !== exp_pack(it.instr, it.pc, 1'b0, 1'b0)) begin
          n_fail++;
          $display("FAIL stream_data #%0d: got %h want %h", rcvd, obs_a,
                   exp_pack(it.instr, it.pc, 1'b0, 1'b1));
        end
      end
      if (in_valid && a_ready) begin
        it.instr = in_instr;
        it.pc    = in_pc;
        q.push_back(it);
        sent++;
      end
      stalled = a_valid && !out_ready;
      snap_a  = obs_a;
      snap_b  = obs_b;
    end
    n_tests++;
    if (rcvd != n) begin
      n_fail++;
      $display("FAIL stream_timeout: delivered %0d want %0d", rcvd, n);
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    n_tests++;
    if (a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: out_valid=%b want 0 (duplicate entry)", a_valid);
    end
  endtask

  task automatic test_flush();
    bit seen;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h10;
    step();
    in_instr = 32'h00200113; in_pc = 64'h14;
    step();
    n_tests++;
    if (a_ready !== 1'b0 || a_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_fill: in_ready=%b out_valid=%b want 0/1", a_ready, a_valid);
    end
    in_instr = 32'h00300193; in_pc = 64'h18; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (a_valid !== 1'b0 || a_ready !== 1'b1 || b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_full: out_valid=%b in_ready=%b want 0/1", a_valid, a_ready);
    end
    in_valid = 1'b1; in_instr = 32'h00400213; in_pc = 64'h1C;
    step();
    in_instr = 32'h00500293; in_pc = 64'h20; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_tests++;
    if (a_valid !== 1'b0 || a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_accept: out_valid=%b in_ready=%b want 0/1", a_valid, a_ready);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (a_valid !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL flush_leak: out_valid=1 after flush, want 0");
    end
    out_ready = 1'b0;
  endtask

  task automatic test_rst_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0080006F; in_pc = 64'h400;
    step();
    in_instr = 32'hFE000EE3; in_pc = 64'h404;
    step();
    in_instr = 32'h800000B7; rst = 1'b1;
    step();
    n_tests++;
    if (a_ready !== 1'b0 || a_valid !== 1'b0 || obs_a !== '0 || obs_b !== '0 || obs_c !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: in_ready=%b out_valid=%b data=%h want 0", a_ready, a_valid, obs_a);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_tests++;
    if (a_ready !== 1'b1 || a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_after: in_ready=%b out_valid=%b want 1/0", a_ready, a_valid);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_stream(8, 1'b0);
    test_stream(8, 1'b1);
    test_stream(40, 1'b1);
    test_flush();
    test_rst_mid();
    test_stream(12, 1'b1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
